bitstream_integ_sched: RTL

- Time-multiplexes one shared `integrator` among NCH bitstream sources.
- Arbitrates requesters round-robin and routes the granted channel's bitstream to the integrator's x input.
- Drives capture for exactly the programmed window length, waits out the integrator's output latency, then returns the count tagged with the channel ID over a valid/ready interface.
- Sits between the bitstream generator bank and the readout logic.

---
 rtl/bitstream_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 23 ++
 rtl/bitstream_integ_sched.sv | 72 +++++++
 3 files changed

// File: rtl/bitstream_pkg.sv
// bitstream_pkg: shared types and constants for the bitstream integrator scheduler
package bitstream_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT, RESULT} sched_state_t;
  localparam int RESULT_W = 32;
  localparam int RES_LAT_DEF = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NCH = 4,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [CH_W-1:0] idx
);
  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0] rot;
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NCH-1:0];
  // Scan from the farthest offset down so the nearest set bit wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (rot[i]) idx = CH_W'((int'(ptr) + i) % NCH);
    gnt[idx] = |req;
  end
endmodule

// File: rtl/bitstream_integ_sched.sv
// bitstream_integ_sched: time-multiplexes one integrator among NCH bitstream sources
module bitstream_integ_sched import bitstream_pkg::*; #(
  parameter int NCH = 4,
  parameter int LEN_W = 16,
  parameter int RES_LAT = RES_LAT_DEF,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NCH-1:0]      req,
  input  logic [LEN_W-1:0]    window_len,
  input  logic [NCH-1:0]      src_x,
  output logic                x,
  output logic                capture,
  input  logic [RESULT_W-1:0] int_y,
  output logic [NCH-1:0]      grant,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RESULT_W-1:0] res_data,
  output logic [CH_W-1:0]     res_ch
);
  sched_state_t state;
  logic [CH_W-1:0] rr_ptr, gidx, arb_idx;
  logic [NCH-1:0] arb_gnt;
  logic [LEN_W-1:0] len_cnt;
  rr_arbiter #(.NCH(NCH)) u_arb (.req(req), .ptr(rr_ptr), .gnt(arb_gnt), .idx(arb_idx));
  assign x = |(src_x & grant);
  assign busy = state != IDLE;
  // len_cnt counts down the capture window, then is reused for the output latency wait
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      grant <= '0;
      gidx <= '0;
      capture <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_ch <= '0;
      rr_ptr <= '0;
      len_cnt <= '0;
    end else
      case (state)
        IDLE: if (|req) begin
          grant <= arb_gnt;
          gidx <= arb_idx;
          rr_ptr <= (arb_idx == CH_W'(NCH - 1)) ? '0 : arb_idx + 1'b1;
          len_cnt <= window_len - 1'b1;
          capture <= |window_len;
          res_valid <= ~|window_len;
          res_data <= '0;
          res_ch <= arb_idx;
          state <= (|window_len) ? CAPTURE : RESULT;
        end
        CAPTURE: if (len_cnt == '0) begin
          capture <= 1'b0;
          len_cnt <= LEN_W'(RES_LAT);
          state <= WAIT;
        end else len_cnt <= len_cnt - 1'b1;
        WAIT: if (len_cnt == '0) begin
          res_data <= int_y;
          res_ch <= gidx;
          res_valid <= 1'b1;
          state <= RESULT;
        end else len_cnt <= len_cnt - 1'b1;
        RESULT: if (res_ready) begin
          res_valid <= 1'b0;
          grant <= '0;
          state <= IDLE;
        end
      endcase
endmodule
